sbp_stage_mem_update_ctrl: RTL and testbench

Arbitrates one lookup stage's single-port stage memory between the lookup pipeline (read every valid slot) and control-plane route updates (writes). Buffers updates in a small FIFO, commits them only in bubble slots (`pipe_valid_i` low), and requests a bubble from the pipeline injector (`hold_o`) if an update waits too long. One instance per stage, between the stage's `addr`/`write` and the stage memory.

---
 rtl/sbp_stage_mem_update_ctrl.sv | 138 +++++++++++++
 tb/tb_sbp_stage_mem_update_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbp_stage_mem_update_ctrl.sv
// Stage-memory port arbiter: lookups read every valid slot, queued route updates commit in bubbles.
// Optional SBP_UPD_STATS_EN adds saturating commit / hold-entry counters.
module sbp_stage_mem_update_ctrl #(
    parameter int ADDR_BITS  = 11,
    parameter int DATA_BITS  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pipe_valid_i,
    input  logic [ADDR_BITS-1:0]            pipe_addr_i,
    input  logic                            upd_valid_i,
    output logic                            upd_ready_o,
    input  logic [ADDR_BITS-1:0]            upd_addr_i,
    input  logic [DATA_BITS-1:0]            upd_data_i,
    output logic                            mem_write_o,
    output logic [ADDR_BITS-1:0]            mem_addr_o,
    output logic [DATA_BITS-1:0]            mem_wdata_o,
    output logic                            hold_o,
    output logic [$clog2(FIFO_DEPTH):0]     upd_pending_o
`ifdef SBP_UPD_STATS_EN
    ,
    output logic [15:0]                     stat_commits_o,
    output logic [15:0]                     stat_holds_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_HOLD} state_t;

    logic [ADDR_BITS-1:0] r_addr_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_nxt;
    state_t               r_state, w_state_nxt;
    logic [7:0]           r_wait, w_wait_nxt;
    logic                 w_empty, w_full, w_push, w_commit;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));

    // Ready depends only on registered count so a same-cycle pop never frees a slot.
    assign upd_ready_o = rst && !w_full;
    assign w_push      = upd_valid_i && upd_ready_o;
    assign w_commit    = rst && !pipe_valid_i && !w_empty;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_commit);

    assign mem_write_o   = w_commit;
    assign mem_addr_o    = w_commit ? r_addr_mem[r_rptr] : pipe_addr_i;
    assign mem_wdata_o   = w_empty ? '0 : r_data_mem[r_rptr];
    assign hold_o        = (r_state == ST_HOLD);
    assign upd_pending_o = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wptr] <= upd_addr_i;
            r_data_mem[r_wptr] <= upd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            if (w_push)   r_wptr <= r_wptr + 1'b1;
            if (w_commit) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            ST_IDLE: begin
                w_wait_nxt = '0;
                if (w_count_nxt != '0) w_state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = '0;
                end else if (w_commit) begin
                    w_wait_nxt  = '0;
                end else if (r_wait == WAIT_MAX) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_wait_nxt  = r_wait + 8'd1;
                end
            end
            ST_HOLD: begin
                // Hold persists until the queue fully drains, even across new pushes.
                if (w_count_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = '0;
                end else if (w_commit) begin
                    w_wait_nxt  = '0;
                end else if (r_wait != WAIT_MAX) begin
                    w_wait_nxt  = r_wait + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = '0;
            end
        endcase
    end

`ifdef SBP_UPD_STATS_EN
    logic r_unused_stats;
    logic w_hold_entry;
    assign w_hold_entry = (r_state == ST_PEND) && (w_state_nxt == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_commits_o <= '0;
            stat_holds_o   <= '0;
            r_unused_stats <= 1'b0;
        end else begin
            if (w_commit && stat_commits_o != 16'hFFFF)   stat_commits_o <= stat_commits_o + 16'd1;
            if (w_hold_entry && stat_holds_o != 16'hFFFF) stat_holds_o   <= stat_holds_o + 16'd1;
            r_unused_stats <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sbp_stage_mem_update_ctrl.sv
// Directed bench for sbp_stage_mem_update_ctrl (default parameters).
module tb_sbp_stage_mem_update_ctrl;

    localparam int AW = 11;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_valid_i;
    logic [AW-1:0] pipe_addr_i;
    logic          upd_valid_i;
    logic          upd_ready_o;
    logic [AW-1:0] upd_addr_i;
    logic [DW-1:0] upd_data_i;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          hold_o;
    logic [2:0]    upd_pending_o;
`ifdef SBP_UPD_STATS_EN
    logic [15:0]   stat_commits_o;
    logic [15:0]   stat_holds_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    sbp_stage_mem_update_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_valid_i  (pipe_valid_i),
        .pipe_addr_i   (pipe_addr_i),
        .upd_valid_i   (upd_valid_i),
        .upd_ready_o   (upd_ready_o),
        .upd_addr_i    (upd_addr_i),
        .upd_data_i    (upd_data_i),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .hold_o        (hold_o),
        .upd_pending_o (upd_pending_o)
`ifdef SBP_UPD_STATS_EN
        ,
        .stat_commits_o(stat_commits_o),
        .stat_holds_o  (stat_holds_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pipe_valid_i = 1'b0; pipe_addr_i = 11'h3A5;
        upd_valid_i = 1'b1; upd_addr_i = 11'h001; upd_data_i = 64'h1;
        tick(); tick(); settle();
        n_vec++; if (upd_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready got %0b want 0", upd_ready_o); end
        n_vec++; if (mem_write_o !== 1'b0) begin n_err++; $display("FAIL rst_write got %0b want 0", mem_write_o); end
        n_vec++; if (mem_addr_o !== 11'h3A5) begin n_err++; $display("FAIL rst_addr got %h want 3a5", mem_addr_o); end
        n_vec++; if (hold_o !== 1'b0) begin n_err++; $display("FAIL rst_hold got %0b want 0", hold_o); end
        n_vec++; if (upd_pending_o !== 3'd0) begin n_err++; $display("FAIL rst_pending got %0d want 0", upd_pending_o); end
        upd_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        n_vec++; if (upd_pending_o !== 3'd0) begin n_err++; $display("FAIL rst_nopush got %0d want 0", upd_pending_o); end
    endtask

    task automatic test_idle_pipe();
        pipe_valid_i = 1'b0; pipe_addr_i = 11'h0FF;
        upd_valid_i = 1'b1; upd_addr_i = 11'h005; upd_data_i = 64'hDEADBEEF_00000001;
        settle();
        n_vec++; if (upd_ready_o !== 1'b1) begin n_err++; $display("FAIL idle_ready got %0b want 1", upd_ready_o); end
        n_vec++; if (mem_write_o !== 1'b0 || mem_wdata_o !== 64'd0) begin n_err++; $display("FAIL idle_empty wr %0b data %h want 0/0", mem_write_o, mem_wdata_o); end
        tick();
        upd_valid_i = 1'b0;
        settle();
        n_vec++; if (upd_pending_o !== 3'd1) begin n_err++; $display("FAIL idle_pending got %0d want 1", upd_pending_o); end
        n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== 11'h005 || mem_wdata_o !== 64'hDEADBEEF_00000001) begin
            n_err++; $display("FAIL idle_commit wr %0b addr %h data %h want 1/005/deadbeef00000001", mem_write_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        n_vec++; if (upd_pending_o !== 3'd0 || mem_write_o !== 1'b0 || mem_addr_o !== 11'h0FF) begin
            n_err++; $display("FAIL idle_drained pend %0d wr %0b addr %h want 0/0/0ff", upd_pending_o, mem_write_o, mem_addr_o);
        end
    endtask

    task automatic test_busy_pipe();
        pipe_valid_i = 1'b1; pipe_addr_i = 11'h123;
        upd_valid_i = 1'b1; upd_addr_i = 11'h777; upd_data_i = 64'h0123_4567_89AB_CDEF;
        tick();
        upd_valid_i = 1'b0;
        settle();
        n_vec++; if (mem_write_o !== 1'b0 || mem_addr_o !== 11'h123 || upd_pending_o !== 3'd1) begin
            n_err++; $display("FAIL busy_read wr %0b addr %h pend %0d want 0/123/1", mem_write_o, mem_addr_o, upd_pending_o);
        end
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_vec++; if (hold_o !== (i == 16)) begin n_err++; $display("FAIL busy_hold_t%0d got %0b want %0b", i, hold_o, (i == 16)); end
        end
        pipe_valid_i = 1'b0;
        settle();
        n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== 11'h777 || mem_wdata_o !== 64'h0123_4567_89AB_CDEF) begin
            n_err++; $display("FAIL busy_commit wr %0b addr %h data %h want 1/777/0123456789abcdef", mem_write_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        pipe_valid_i = 1'b1;
        settle();
        n_vec++; if (hold_o !== 1'b0 || upd_pending_o !== 3'd0 || mem_write_o !== 1'b0) begin
            n_err++; $display("FAIL busy_release hold %0b pend %0d wr %0b want 0/0/0", hold_o, upd_pending_o, mem_write_o);
        end
    endtask

    task automatic test_full_fifo();
        pipe_valid_i = 1'b1; pipe_addr_i = 11'h200;
        for (int i = 1; i <= 5; i++) begin
            upd_valid_i = 1'b1; upd_addr_i = AW'(i); upd_data_i = {32'hA5A5_0000, 32'(i)};
            settle();
            n_vec++; if (upd_ready_o !== (i <= 4)) begin n_err++; $display("FAIL full_ready_%0d got %0b want %0b", i, upd_ready_o, (i <= 4)); end
            tick();
        end
        upd_valid_i = 1'b0;
        settle();
        n_vec++; if (upd_pending_o !== 3'd4 || upd_ready_o !== 1'b0) begin
            n_err++; $display("FAIL full_state pend %0d ready %0b want 4/0", upd_pending_o, upd_ready_o);
        end
        pipe_valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            settle();
            n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== AW'(i) || mem_wdata_o !== {32'hA5A5_0000, 32'(i)}) begin
                n_err++; $display("FAIL full_commit_%0d wr %0b addr %h data %h", i, mem_write_o, mem_addr_o, mem_wdata_o);
            end
            tick();
        end
        pipe_valid_i = 1'b1;
        settle();
        n_vec++; if (upd_pending_o !== 3'd0 || mem_write_o !== 1'b0) begin
            n_err++; $display("FAIL full_drained pend %0d wr %0b want 0/0", upd_pending_o, mem_write_o);
        end
    endtask

    task automatic test_same_addr();
        pipe_valid_i = 1'b1; pipe_addr_i = 11'h300;
        upd_valid_i = 1'b1; upd_addr_i = 11'h010; upd_data_i = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        upd_data_i = 64'hBBBB_BBBB_BBBB_BBBB;
        tick();
        upd_valid_i = 1'b0; pipe_valid_i = 1'b0;
        settle();
        n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== 11'h010 || mem_wdata_o !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            n_err++; $display("FAIL same_first wr %0b addr %h data %h want 1/010/aaaa..", mem_write_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== 11'h010 || mem_wdata_o !== 64'hBBBB_BBBB_BBBB_BBBB) begin
            n_err++; $display("FAIL same_second wr %0b addr %h data %h want 1/010/bbbb..", mem_write_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        n_vec++; if (upd_pending_o !== 3'd0) begin n_err++; $display("FAIL same_drained got %0d want 0", upd_pending_o); end
    endtask

    task automatic test_back_to_back();
        pipe_valid_i = 1'b0; pipe_addr_i = 11'h050;
        for (int i = 0; i < 3; i++) begin
            upd_valid_i = 1'b1; upd_addr_i = AW'(11'h020 + i); upd_data_i = 64'(i + 7);
            settle();
            if (i > 0) begin
                n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== AW'(11'h020 + i - 1) || upd_pending_o !== 3'd1) begin
                    n_err++; $display("FAIL b2b_%0d wr %0b addr %h pend %0d", i, mem_write_o, mem_addr_o, upd_pending_o);
                end
            end
            tick();
        end
        upd_valid_i = 1'b0;
        settle();
        n_vec++; if (mem_write_o !== 1'b1 || mem_addr_o !== 11'h022 || mem_wdata_o !== 64'd9) begin
            n_err++; $display("FAIL b2b_last wr %0b addr %h data %h want 1/022/9", mem_write_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        n_vec++; if (upd_pending_o !== 3'd0) begin n_err++; $display("FAIL b2b_drained got %0d want 0", upd_pending_o); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        pipe_valid_i = 1'b1; pipe_addr_i = 11'h111;
        for (int i = 0; i < 3; i++) begin
            upd_valid_i = 1'b1; upd_addr_i = AW'(11'h040 + i); upd_data_i = 64'(i);
            tick();
        end
        upd_valid_i = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            tick();
            seen = hold_o;
        end
        n_vec++; if (!seen || upd_pending_o !== 3'd3) begin n_err++; $display("FAIL rmid_hold seen %0b pend %0d want 1/3", seen, upd_pending_o); end
        rst = 1'b0; pipe_valid_i = 1'b0;
        settle();
        n_vec++; if (mem_write_o !== 1'b0 || mem_addr_o !== 11'h111) begin
            n_err++; $display("FAIL rmid_gate wr %0b addr %h want 0/111", mem_write_o, mem_addr_o);
        end
        tick();
        rst = 1'b1;
        settle();
        n_vec++; if (upd_pending_o !== 3'd0 || hold_o !== 1'b0) begin
            n_err++; $display("FAIL rmid_after pend %0d hold %0b want 0/0", upd_pending_o, hold_o);
        end
        for (int t = 0; t < 3; t++) begin
            n_vec++; if (mem_write_o !== 1'b0) begin n_err++; $display("FAIL rmid_nowrite_%0d got %0b want 0", t, mem_write_o); end
            tick();
        end
    endtask

`ifdef SBP_UPD_STATS_EN
    task automatic test_stats();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        test_busy_pipe();
        test_busy_pipe();
        n_vec++; if (stat_holds_o !== 16'd2 || stat_commits_o !== 16'd2) begin
            n_err++; $display("FAIL stats holds %0d commits %0d want 2/2", stat_holds_o, stat_commits_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_pipe();
        test_busy_pipe();
        test_full_fifo();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
`ifdef SBP_UPD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
